ps2_voice_alloc: RTL and testbench

PS2_VOICE_ALLOC -- requirements
Module: ps2_voice_alloc

---
 rtl/ps2_voice_alloc.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_voice_alloc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_voice_alloc.sv
// PS/2 scan-code decoder that assigns set-2 note keys to 4 voices, with oldest-voice stealing.
// Latency: 1 cycle from code_valid to the voice state and event outputs. No backpressure: every strobe is consumed.
// Behaviour when full: a make with all voices busy steals the oldest voice when STEAL_EN=1, and is dropped otherwise.
module ps2_voice_alloc #(
    parameter bit         STEAL_EN  = 1'b1,
    parameter logic [7:0] IDLE_CODE = 8'hF0
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        code_valid,
    input  logic [7:0]  code,
    input  logic        flush,
    output logic [3:0]  voice_on,
    output logic [31:0] voice_code,
    output logic        ev_valid,
    output logic        ev_on,
    output logic [1:0]  ev_voice,
    output logic [7:0]  ev_code,
    output logic        ev_steal
);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_on, w_on_nxt;
    logic [7:0] r_code [4];
    logic [7:0] w_code_nxt [4];
    logic [1:0] r_age [4];
    logic [1:0] w_age_nxt [4];
    logic       r_ev_vld, r_ev_on, r_ev_steal;
    logic [1:0] r_ev_voice;
    logic [7:0] r_ev_code;
    logic       w_ev_vld, w_ev_on, w_ev_steal;
    logic [1:0] w_ev_voice;
    logic [7:0] w_ev_code;

    logic       w_is_make, w_is_break, w_discard;
    logic       w_hit, w_free, w_alloc, w_steal;
    logic [1:0] w_hit_idx, w_free_idx, w_old_idx, w_old_age, w_tgt, w_prior;

    function automatic logic f_key(input logic [7:0] c);
        case (c)
            8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C,
            8'h52, 8'h5B, 8'h4D, 8'h44, 8'h43, 8'h35, 8'h2C, 8'h24, 8'h1D, 8'h15: f_key = 1'b1;
            default: f_key = 1'b0;
        endcase
    endfunction

    // Link-level bytes (ack, BAT, echo, resend, errors) abort any prefix in progress
    assign w_discard = (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
                       (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);

    always_comb begin
        w_state_nxt = r_state;
        w_is_make   = 1'b0;
        w_is_break  = 1'b0;
        if (code_valid) begin
            if (w_discard) begin
                w_state_nxt = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (code == 8'hF0)      w_state_nxt = S_BRK;
                        else if (code == 8'hE0) w_state_nxt = S_EXT;
                        else                    w_is_make   = 1'b1;
                    end
                    S_BRK: begin
                        if (code == 8'hF0)      w_state_nxt = S_BRK;
                        else if (code == 8'hE0) w_state_nxt = S_EXT;
                        else begin
                            w_is_break  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_EXT:   w_state_nxt = (code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = 2'd0;
        w_free     = 1'b0;
        w_free_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_on[i] && (r_code[i] == code)) begin
                w_hit     = 1'b1;
                w_hit_idx = 2'(i);
            end
            if (!r_on[i]) begin
                w_free     = 1'b1;
                w_free_idx = 2'(i);
            end
        end
        w_old_idx = 2'd0;
        w_old_age = r_age[0];
        for (int i = 1; i < 4; i++) begin
            if (r_age[i] > w_old_age) begin
                w_old_idx = 2'(i);
                w_old_age = r_age[i];
            end
        end
    end

    always_comb begin
        w_on_nxt   = r_on;
        w_code_nxt = r_code;
        w_age_nxt  = r_age;
        w_ev_vld   = 1'b0;
        w_ev_on    = r_ev_on;
        w_ev_voice = r_ev_voice;
        w_ev_code  = r_ev_code;
        w_ev_steal = r_ev_steal;
        w_alloc    = 1'b0;
        w_steal    = 1'b0;
        w_tgt      = w_free_idx;
        w_prior    = 2'd3;
        if (w_is_make && f_key(code) && !w_hit) begin
            if (w_free) begin
                w_alloc = 1'b1;
            end else if (STEAL_EN) begin
                w_alloc = 1'b1;
                w_steal = 1'b1;
                w_tgt   = w_old_idx;
                w_prior = w_old_age;
            end
        end
        if (w_alloc) begin
            // Voices younger than the target's previous slot shift one step older
            for (int i = 0; i < 4; i++) begin
                if (r_on[i] && (r_age[i] < w_prior)) w_age_nxt[i] = r_age[i] + 2'd1;
            end
            w_on_nxt[w_tgt]   = 1'b1;
            w_code_nxt[w_tgt] = code;
            w_age_nxt[w_tgt]  = 2'd0;
            w_ev_vld          = 1'b1;
            w_ev_on           = 1'b1;
            w_ev_voice        = w_tgt;
            w_ev_code         = code;
            w_ev_steal        = w_steal;
        end else if (w_is_break && w_hit) begin
            w_on_nxt[w_hit_idx]   = 1'b0;
            w_code_nxt[w_hit_idx] = IDLE_CODE;
            w_age_nxt[w_hit_idx]  = 2'd3;
            w_ev_vld              = 1'b1;
            w_ev_on               = 1'b0;
            w_ev_voice            = w_hit_idx;
            w_ev_code             = code;
            w_ev_steal            = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_on       <= 4'd0;
            r_ev_vld   <= 1'b0;
            r_ev_on    <= 1'b0;
            r_ev_voice <= 2'd0;
            r_ev_code  <= 8'd0;
            r_ev_steal <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_code[i] <= IDLE_CODE;
                r_age[i]  <= 2'd3;
            end
        end else if (flush) begin
            r_state  <= S_IDLE;
            r_on     <= 4'd0;
            r_ev_vld <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_code[i] <= IDLE_CODE;
                r_age[i]  <= 2'd3;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_on       <= w_on_nxt;
            r_code     <= w_code_nxt;
            r_age      <= w_age_nxt;
            r_ev_vld   <= w_ev_vld;
            r_ev_on    <= w_ev_on;
            r_ev_voice <= w_ev_voice;
            r_ev_code  <= w_ev_code;
            r_ev_steal <= w_ev_steal;
        end
    end

    always_comb begin
        voice_code = 32'd0;
        for (int i = 0; i < 4; i++) voice_code[8*i +: 8] = r_code[i];
    end

    assign voice_on = r_on;
    assign ev_valid = r_ev_vld;
    assign ev_on    = r_ev_on;
    assign ev_voice = r_ev_voice;
    assign ev_code  = r_ev_code;
    assign ev_steal = r_ev_steal;

endmodule

// File: tb/tb_ps2_voice_alloc.sv
// Scoreboard bench: two instances (stealing on and off) share the stimulus; expected events are queued per instance.
module tb_ps2_voice_alloc;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        reset, code_valid, flush;
    logic [7:0]  code;
    logic [3:0]  von1, von0;
    logic [31:0] vc1, vc0;
    logic        evv1, evo1, evs1, evv0, evo0, evs0;
    logic [1:0]  evi1, evi0;
    logic [7:0]  evc1, evc0;

    ps2_voice_alloc #(.STEAL_EN(1'b1), .IDLE_CODE(8'hF0)) dut1 (
        .sys_clk(sys_clk), .reset(reset), .code_valid(code_valid), .code(code), .flush(flush),
        .voice_on(von1), .voice_code(vc1), .ev_valid(evv1), .ev_on(evo1),
        .ev_voice(evi1), .ev_code(evc1), .ev_steal(evs1));

    ps2_voice_alloc #(.STEAL_EN(1'b0), .IDLE_CODE(8'hF0)) dut0 (
        .sys_clk(sys_clk), .reset(reset), .code_valid(code_valid), .code(code), .flush(flush),
        .voice_on(von0), .voice_code(vc0), .ev_valid(evv0), .ev_on(evo0),
        .ev_voice(evi0), .ev_code(evc0), .ev_steal(evs0));

    typedef struct {
        logic       on;
        logic [1:0] v;
        logic [7:0] c;
        logic       st;
        int         due;
    } exp_t;

    exp_t q [2][$];
    int n_tests = 0;
    int n_fail  = 0;
    int pcnt    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic vld, input logic on, input logic [1:0] v,
                       input logic [7:0] c, input logic st);
        exp_t e;
        if (q[d].size() > 0 && q[d][0].due == pcnt) begin
            e = q[d].pop_front();
            chk($sformatf("u%0d_ev_valid", d), vld, 1);
            chk($sformatf("u%0d_ev_on", d), on, e.on);
            chk($sformatf("u%0d_ev_voice", d), v, e.v);
            chk($sformatf("u%0d_ev_code", d), c, e.c);
            chk($sformatf("u%0d_ev_steal", d), st, e.st);
        end else if (vld) begin
            chk($sformatf("u%0d_ev_unexpected", d), vld, 0);
        end
    endtask

    always @(posedge sys_clk) begin
        #1;
        pcnt++;
        mon(0, evv1, evo1, evi1, evc1, evs1);
        mon(1, evv0, evo0, evi0, evc0, evs0);
    end

    // Called at a falling edge; the byte is sampled at the following rising edge.
    task automatic send_x(input logic [7:0] c, input logic e1, input logic e0,
                          input logic on, input logic [1:0] v, input logic st);
        exp_t e;
        e.on = on; e.v = v; e.c = c; e.st = st; e.due = pcnt + 1;
        if (e1) q[0].push_back(e);
        if (e0) q[1].push_back(e);
        code       = c;
        code_valid = 1'b1;
        @(negedge sys_clk);
        code_valid = 1'b0;
    endtask

    task automatic s(input logic [7:0] c);
        send_x(c, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic son(input logic [7:0] c, input logic [1:0] v);
        send_x(c, 1'b1, 1'b1, 1'b1, v, 1'b0);
    endtask

    task automatic soff(input logic [7:0] c, input logic [1:0] v);
        send_x(c, 1'b1, 1'b1, 1'b0, v, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b1;
        code_valid = 1'b1;
        code       = 8'h1C;
        repeat (3) @(negedge sys_clk);
        chk("rst_voice_on", von1, 4'h0);
        chk("rst_voice_code", vc1, 32'hF0F0F0F0);
        chk("rst_ev_valid", evv1, 0);
        chk("rst_ev_on", evo1, 0);
        chk("rst_ev_voice", evi1, 0);
        chk("rst_ev_code", evc1, 0);
        chk("rst_ev_steal", evs1, 0);
        chk("rst_voice_on_u1", von0, 4'h0);
        reset      = 1'b1;
        flush      = 1'b0;
        code_valid = 1'b0;
        @(negedge sys_clk);

        // Two makes back to back, then release both
        son(8'h1C, 2'd0);
        son(8'h1B, 2'd1);
        chk("two_make_on", von1, 4'h3);
        chk("two_make_code", vc1, 32'hF0F01B1C);
        chk("two_make_on_u1", von0, 4'h3);
        s(8'hF0); soff(8'h1C, 2'd0);
        s(8'hF0); soff(8'h1B, 2'd1);
        chk("release_on", von1, 4'h0);

        // Typematic repeat gives a single note-on
        son(8'h1C, 2'd0);
        s(8'h1C); s(8'h1C);
        s(8'hF0); soff(8'h1C, 2'd0);
        chk("typematic_on", von1, 4'h0);
        chk("typematic_code", vc1, 32'hF0F0F0F0);
        @(negedge sys_clk);
        chk("hold_ev_valid", evv1, 0);
        chk("hold_ev_code", evc1, 8'h1C);
        chk("hold_ev_on", evo1, 0);

        // Fill all voices, then steal the oldest (only the stealing instance reacts)
        son(8'h1C, 2'd0); son(8'h1B, 2'd1); son(8'h23, 2'd2); son(8'h2B, 2'd3);
        send_x(8'h34, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
        chk("steal1_code", vc1, 32'h2B231B34);
        chk("nosteal_code", vc0, 32'h2B231B1C);
        send_x(8'h33, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
        chk("steal2_code", vc1, 32'h2B233334);
        s(8'hF0); soff(8'h2B, 2'd3);
        son(8'h4B, 2'd3);
        send_x(8'h4C, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        chk("steal3_code", vc1, 32'h4B4C3334);
        chk("nosteal3_code", vc0, 32'h4B231B1C);
        chk("nosteal3_on", von0, 4'hF);

        // Flush wins over a simultaneous make
        code       = 8'h15;
        code_valid = 1'b1;
        flush      = 1'b1;
        @(negedge sys_clk);
        code_valid = 1'b0;
        flush      = 1'b0;
        chk("flush_on", von1, 4'h0);
        chk("flush_on_u1", von0, 4'h0);
        chk("flush_code", vc1, 32'hF0F0F0F0);
        chk("flush_ev_valid", evv1, 0);

        // Extended and unmatched sequences are silent
        s(8'hE0); s(8'h75);
        s(8'hE0); s(8'hF0); s(8'h75);
        s(8'hF0); s(8'h33);
        son(8'h33, 2'd0);
        chk("ext_then_make_on", von1, 4'h1);
        s(8'h75);
        s(8'hF0); s(8'hAA); son(8'h1C, 2'd1);
        s(8'hF0); s(8'hE0); s(8'h1C);
        chk("prefix_on", von1, 4'h3);
        chk("prefix_code", vc1, 32'hF0F01C33);

        // Reset in the middle of a break prefix
        s(8'hF0);
        reset = 1'b0;
        @(negedge sys_clk);
        reset = 1'b1;
        chk("midrst_on", von1, 4'h0);
        son(8'h1C, 2'd0);
        chk("midrst_code", vc1, 32'hF0F0F01C);

        repeat (3) @(negedge sys_clk);
        chk("queue0_empty", q[0].size(), 0);
        chk("queue1_empty", q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
